// File: rtl/flit_mux_rr.sv
// flit_mux_rr: parametrised N:1 wormhole flit multiplexer for the router output stage.
// Each packet is a HEAD..TAIL sequence. A packet is granted from IDLE, either
// round-robin or by an external select. The output then stays locked to that port
// until its TAIL has been transferred, so packets are never interleaved.
// The output is registered and uses valid/ready backpressure.
//
// Ports:
//   clk, rst            clock; reset is synchronous and active-high
//   idata/ivalid/ivch   per-port flit, valid and VC id (port p at [p*W +: W])
//   iready              flit on port p is consumed this cycle (combinational)
//   ext_mode/ext_sel    1: grant ext_sel instead of round-robin (used only in IDLE)
//   odata/ovalid/ovch   registered output flit, valid and VC id
//   oready              downstream accepts the output this cycle
//   lock_port           port that currently owns the output
//   busy                high while a packet holds the lock
//   err                 sticky protocol error (stray HEAD or empty flit inside a packet)

// Per-port decode of the flit type field.
module flit_mux_rr_lane #(
  parameter int DATAW = 66
) (
  input  logic [DATAW-1:0] flit,
  input  logic             vld,
  output logic [1:0]       ftype,
  output logic             head_req
);
  assign ftype    = flit[DATAW-1 -: 2];
  assign head_req = vld & (ftype == 2'b01);
endmodule

module flit_mux_rr #(
  parameter  int NPORT = 2,
  parameter  int DATAW = 66,
  parameter  int VCHW  = 1,
  localparam int SELW  = $clog2(NPORT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT*DATAW-1:0] idata,
  input  logic [NPORT-1:0]       ivalid,
  input  logic [NPORT*VCHW-1:0]  ivch,
  output logic [NPORT-1:0]       iready,
  input  logic                   ext_mode,
  input  logic [SELW-1:0]        ext_sel,
  output logic [DATAW-1:0]       odata,
  output logic                   ovalid,
  output logic [VCHW-1:0]        ovch,
  input  logic                   oready,
  output logic [SELW-1:0]        lock_port,
  output logic                   busy,
  output logic                   err
);
  localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_DATA = 2'b10, T_TAIL = 2'b11;
  localparam int NPAD = 1 << SELW;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                       state, state_n;
  logic [SELW-1:0]              ptr;
  logic [NPORT-1:0][DATAW-1:0]  din;
  logic [NPORT-1:0][VCHW-1:0]   vin;
  logic [NPORT-1:0][1:0]        ftype;
  logic [NPORT-1:0]             head_req;
  logic [NPAD-1:0]              head_pad;
  logic                         rr_hit, adv, xfer, set_err, tail_done;
  logic [SELW-1:0]              rr_gnt, sel;

  assign din  = idata;
  assign vin  = ivch;
  assign adv  = !ovalid | oready;
  assign busy = (state == LOCKED);

  for (genvar p = 0; p < NPORT; p++) begin : g_lane
    flit_mux_rr_lane #(.DATAW(DATAW)) u_lane (
      .flit     (din[p]),
      .vld      (ivalid[p]),
      .ftype    (ftype[p]),
      .head_req (head_req[p])
    );
  end

  // Zero-padded so an out-of-range ext_sel simply selects "no candidate".
  always_comb begin
    head_pad           = '0;
    head_pad[NPORT-1:0] = head_req;
  end

  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NPORT) s = s - NPORT;
    return SELW'(s);
  endfunction

  // First HEAD at/after ptr; scanning downwards lets the lowest offset win.
  always_comb begin
    rr_hit = 1'b0;
    rr_gnt = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (head_req[wrap_add(ptr, k)]) begin
        rr_hit = 1'b1;
        rr_gnt = wrap_add(ptr, k);
      end
    end
  end

  always_comb begin
    state_n   = state;
    iready    = '0;
    xfer      = 1'b0;
    set_err   = 1'b0;
    tail_done = 1'b0;
    sel       = lock_port;
    unique case (state)
      IDLE: begin
        if (ext_mode ? head_pad[ext_sel] : rr_hit) begin
          sel = ext_mode ? ext_sel : rr_gnt;
          if (adv) begin
            iready[sel] = 1'b1;
            xfer        = 1'b1;
            state_n     = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (ivalid[lock_port] && adv) begin
          iready[lock_port] = 1'b1;
          unique case (ftype[lock_port])
            T_NONE: set_err = 1'b1;                      // consumed and dropped
            T_HEAD: begin xfer = 1'b1; set_err = 1'b1; end
            T_DATA: xfer = 1'b1;
            T_TAIL: begin xfer = 1'b1; tail_done = 1'b1; state_n = IDLE; end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      odata     <= '0;
      ovalid    <= 1'b0;
      ovch      <= '0;
      lock_port <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      if (set_err) err <= 1'b1;
      if (state == IDLE && xfer) lock_port <= sel;
      if (tail_done && !ext_mode) ptr <= wrap_add(lock_port, 1);
      if (adv) begin
        ovalid <= xfer;
        odata  <= din[sel];
        ovch   <= vin[sel];
      end
    end
  end
endmodule

// File: tb/tb_flit_mux_rr.sv
// Self-checking bench for flit_mux_rr (NPORT=5, so that ext_sel=5..7 is out of range).
// Source queues feed the ports. Expected output flits are queued in predicted order
// when the packets are enqueued, and are popped on each output handshake.
module tb_flit_mux_rr;
  localparam int NP = 5, DW = 66, VW = 2, SW = $clog2(NP), EW = DW + VW;
  localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_DATA = 2'b10, T_TAIL = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0][DW-1:0] din, din_d, din_t;
  logic [NP-1:0][VW-1:0] vin, vin_d;
  logic [NP-1:0]         ivalid, iv_d, iv_t, iready;
  logic                  ext_mode, ovalid, oready, busy, err;
  logic [SW-1:0]         ext_sel, lock_port;
  logic [DW-1:0]         odata;
  logic [VW-1:0]         ovch;

  bit drv_en = 0, mon_en = 0, t2 = 0, t3 = 0, t6 = 0;
  logic [EW-1:0] src_q[NP][$];
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;

  assign ivalid = drv_en ? iv_d  : iv_t;
  assign din    = drv_en ? din_d : din_t;
  assign vin    = drv_en ? vin_d : '0;

  flit_mux_rr #(.NPORT(NP), .DATAW(DW), .VCHW(VW)) dut (
    .clk(clk), .rst(rst), .idata(din), .ivalid(ivalid), .ivch(vin), .iready(iready),
    .ext_mode(ext_mode), .ext_sel(ext_sel), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .oready(oready), .lock_port(lock_port), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [1:0] t, input int p, input int pk,
                                       input int i, input logic [VW-1:0] v);
    return {v, t, 32'(p), 16'(pk), 16'(i)};
  endfunction

  task automatic push(input int p, input logic [EW-1:0] e, input bit fwd);
    src_q[p].push_back(e);
    if (fwd) exp_q.push_back(e);
  endtask

  task automatic push_pkt(input int p, input int pk, input int nd, input logic [VW-1:0] v,
                          input bit fwd);
    push(p, mk(T_HEAD, p, pk, 0, v), fwd);
    for (int i = 1; i <= nd; i++) push(p, mk(T_DATA, p, pk, i, v), fwd);
    push(p, mk(T_TAIL, p, pk, nd + 1, v), fwd);
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string nm, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #2;
      done = (exp_q.size() == 0) && !busy && !ovalid && all_empty();
    end
    chk({nm, "_drain"}, 80'(done), 80'd1);
  endtask

  // Driver + monitor: sample at negedge, advance sources just after posedge.
  logic [NP-1:0] take;
  logic [EW-1:0] hold_v, lat_v;
  bit hold_p = 0, lat_p = 0, gap = 0, gap_p = 0;
  always begin
    @(negedge clk);
    if (mon_en) begin
      chk("one_ready", 80'($countones(iready) <= 1), 80'd1);
      if (ovalid && !oready) chk("stall_no_ready", 80'(iready), 80'd0);
      if (hold_p) chk("stall_hold", 80'({ovalid, ovch, odata}), 80'({1'b1, hold_v}));
      if (lat_p) chk("latency", 80'({ovalid, ovch, odata}), 80'({1'b1, lat_v}));
      if (ovalid && oready) begin
        if (exp_q.size() == 0) chk("sb_extra", 80'(ovalid), 80'd0);
        else chk("sb_flit", 80'({ovch, odata}), 80'(exp_q.pop_front()));
      end
      if (t2) chk("t2_p0_ready", 80'(iready[0]), 80'd0);
      if (t3) begin
        gap = 1'b0;
        for (int p = 0; p < NP; p++)
          if (ivalid[p] && din[p][DW-1 -: 2] == T_HEAD && !busy) gap = 1'b1;
        chk("t3_idle_gap", 80'(gap && gap_p), 80'd0);
        gap_p = gap;
        if (ovalid && odata[DW-1 -: 2] == T_HEAD)
          chk("t3_lock_port", 80'(lock_port), 80'(odata[32 +: SW]));
      end else gap_p = 1'b0;
      if (t6) chk("t6_no_grant", 80'({iready, ovalid}), 80'd0);
    end
    hold_p = mon_en && ovalid && !oready;
    hold_v = {ovch, odata};
    take   = drv_en ? (ivalid & iready) : '0;
    lat_p  = 1'b0;
    for (int p = 0; p < NP; p++)
      if (take[p] && src_q[p][0][DW-1 -: 2] != T_NONE) begin
        lat_p = 1'b1;
        lat_v = src_q[p][0];
      end
    @(posedge clk); #1;
    if (drv_en) begin
      for (int p = 0; p < NP; p++) begin
        if (take[p]) void'(src_q[p].pop_front());
        iv_d[p] = (src_q[p].size() != 0);
        if (iv_d[p]) begin
          din_d[p] = src_q[p][0][DW-1:0];
          vin_d[p] = src_q[p][0][EW-1:DW];
        end
      end
    end
  end

  typedef struct {
    logic [NP-1:0]      vld;
    logic [NP-1:0][1:0] typ;
    logic               em;
    logic [SW-1:0]      es;
    logic [NP-1:0]      rdy;
  } vec_t;
  vec_t vt[13];

  initial begin
    rst = 1'b1; ext_mode = 1'b0; ext_sel = '0; oready = 1'b1;
    iv_t = '0; din_t = '0; iv_d = '0; din_d = '0; vin_d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid", 80'(ovalid), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_err", 80'(err), 80'd0);
    chk("rst_lock", 80'(lock_port), 80'd0);
    chk("rst_odata", 80'(odata), 80'd0);
    chk("rst_ovch", 80'(ovch), 80'd0);

    // IDLE grant decisions, ptr=0, held in reset so the state never moves.
    vt[0]  = '{vld:5'b00000, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:0, es:3'd0, rdy:5'b00000};
    vt[1]  = '{vld:5'b00001, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:0, es:3'd0, rdy:5'b00001};
    vt[2]  = '{vld:5'b11110, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:0, es:3'd0, rdy:5'b00010};
    vt[3]  = '{vld:5'b11111, typ:{T_HEAD,T_HEAD,T_HEAD,T_TAIL,T_DATA}, em:0, es:3'd0, rdy:5'b00100};
    vt[4]  = '{vld:5'b10000, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:0, es:3'd0, rdy:5'b10000};
    vt[5]  = '{vld:5'b11111, typ:{T_NONE,T_NONE,T_NONE,T_NONE,T_NONE}, em:0, es:3'd0, rdy:5'b00000};
    vt[6]  = '{vld:5'b11111, typ:{T_HEAD,T_DATA,T_DATA,T_TAIL,T_NONE}, em:0, es:3'd0, rdy:5'b10000};
    vt[7]  = '{vld:5'b11111, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:1, es:3'd3, rdy:5'b01000};
    vt[8]  = '{vld:5'b11111, typ:{T_HEAD,T_DATA,T_HEAD,T_HEAD,T_HEAD}, em:1, es:3'd3, rdy:5'b00000};
    vt[9]  = '{vld:5'b11111, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:1, es:3'd5, rdy:5'b00000};
    vt[10] = '{vld:5'b11111, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:1, es:3'd7, rdy:5'b00000};
    vt[11] = '{vld:5'b00001, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:1, es:3'd0, rdy:5'b00001};
    vt[12] = '{vld:5'b11011, typ:{T_HEAD,T_HEAD,T_HEAD,T_HEAD,T_HEAD}, em:1, es:3'd2, rdy:5'b00000};
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #2;
      ext_mode = vt[i].em;
      ext_sel  = vt[i].es;
      iv_t     = vt[i].vld;
      for (int p = 0; p < NP; p++) din_t[p] = {vt[i].typ[p], 64'(p)};
      @(negedge clk);
      chk($sformatf("tbl%0d_iready", i), 80'(iready), 80'(vt[i].rdy));
    end
    @(posedge clk); #2; iv_t = '0;
    @(posedge clk); #2; rst = 1'b0; ext_mode = 1'b0; ext_sel = '0; drv_en = 1; mon_en = 1;

    // External select of port 1: a 22-flit packet while port 0 waits with a HEAD.
    ext_mode = 1'b1; ext_sel = 3'd1;
    push_pkt(1, 0, 20, 2'd1, 1'b1);
    push_pkt(0, 0, 1, 2'd2, 1'b1);
    t2 = 1;
    begin
      bit done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(posedge clk); #2;
        done = (src_q[1].size() == 0) && !busy;
      end
      chk("t2_p1_done", 80'(done), 80'd1);
    end
    t2 = 0; ext_sel = 3'd0;
    drain("t2", 100);

    // Round-robin, all ports contending for two rounds.
    ext_mode = 1'b0;
    for (int pk = 1; pk <= 2; pk++)
      for (int p = 0; p < NP; p++) push_pkt(p, pk, 1, VW'(p), 1'b1);
    t3 = 1;
    drain("t3", 200);
    t3 = 0;

    // Backpressure toggling during two packets (ptr is back at 0: port 1 then 3).
    push_pkt(1, 3, 4, 2'd3, 1'b1);
    push_pkt(3, 3, 6, 2'd0, 1'b1);
    begin
      bit done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(posedge clk); #2;
        oready = ~oready;
        done = (exp_q.size() == 0) && !busy && !ovalid && all_empty();
      end
      chk("t4_drain", 80'(done), 80'd1);
    end
    oready = 1'b1;

    // Protocol errors on the locked port: stray HEAD forwarded, NONE dropped.
    chk("t5_err_pre", 80'(err), 80'd0);
    push(2, mk(T_HEAD, 2, 4, 0, 2'd2), 1'b1);
    push(2, mk(T_DATA, 2, 4, 1, 2'd2), 1'b1);
    push(2, mk(T_HEAD, 2, 4, 2, 2'd2), 1'b1);
    push(2, mk(T_DATA, 2, 4, 3, 2'd2), 1'b1);
    push(2, mk(T_NONE, 2, 4, 4, 2'd2), 1'b0);
    push(2, mk(T_DATA, 2, 4, 5, 2'd2), 1'b1);
    push(2, mk(T_TAIL, 2, 4, 6, 2'd2), 1'b1);
    drain("t5", 100);
    chk("t5_err_set", 80'(err), 80'd1);
    push_pkt(0, 5, 2, 2'd1, 1'b1);
    drain("t5b", 100);
    chk("t5_err_sticky", 80'(err), 80'd1);

    // Out-of-range external select: nothing may be granted.
    ext_mode = 1'b1;
    for (int p = 0; p < NP; p++) push_pkt(p, 6, 1, 2'd0, 1'b0);
    t6 = 1;
    for (int es = 5; es < 8; es++) begin
      ext_sel = SW'(es);
      repeat (8) begin @(posedge clk); #2; end
    end
    t6 = 0;

    // Reset in the middle of a packet.
    mon_en = 0; ext_mode = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(negedge clk);
    chk("t1_pre_busy", 80'(busy), 80'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_ovalid", 80'(ovalid), 80'd0);
    chk("t1_busy", 80'(busy), 80'd0);
    chk("t1_err", 80'(err), 80'd0);
    chk("t1_lock", 80'(lock_port), 80'd0);
    rst = 1'b0; drv_en = 0; iv_t = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
